pwm_capture: RTL and testbench

//  Receive side of the motor/servo PWM link: measures high time and period of an incoming 20 ms-frame PWM pulse train.

---
 rtl/motor_pkg.sv | 24 ++
 rtl/pwm_in_cond.sv | 67 ++++++
 rtl/pwm_capture.sv | 162 ++++++++++++++++
 tb/tb_pwm_capture.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the motor/servo PWM link (generator and capture side).
// Holds frame timing constants, command encoding and the capture FSM state type.
package motor_pkg;

   localparam int CLK_HZ     = 50_000_000;
   localparam int PERIOD_CYC = 1_000_000;

   localparam int NARROW_W   = 17_500;
   localparam int MID_BASE_W = 75_260;
   localparam int WIDE_W     = 95_616;

   typedef enum logic [1:0] {
      CMD_MID    = 2'b00,
      CMD_WIDE   = 2'b01,
      CMD_NARROW = 2'b10
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } cap_state_t;

endpackage

// File: rtl/pwm_in_cond.sv
// Input conditioning for pwm_capture: 2-FF synchronizer, optional glitch filter
// (PWM_CAP_FILTER_EN), and rise/fall detection on the resulting level.
module pwm_in_cond #(
   parameter int FILT_LEN = 4
) (
   input  logic m_clock,
   input  logic p_reset,
   input  logic pwm_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [1:0] sync_reg;
   logic [3:0] warm_reg;
   logic       lvl_d_reg;

   if (FILT_LEN < 1) begin : g_len_check
      $error("pwm_in_cond: FILT_LEN must be at least 1");
   end

   // warm_reg marks when the pipeline holds real samples; until then a high
   // input would look like a rise against the reset value and start a partial frame.
   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         sync_reg  <= 2'b00;
         warm_reg  <= 4'b0000;
         lvl_d_reg <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[0], pwm_in};
         warm_reg  <= {warm_reg[2:0], 1'b1};
         lvl_d_reg <= level;
      end
   end

`ifdef PWM_CAP_FILTER_EN
   localparam int FCW = $clog2(FILT_LEN + 1);

   logic [FCW-1:0] fcnt_reg;
   logic           filt_reg;

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         filt_reg <= 1'b0;
         fcnt_reg <= '0;
      end else if (!warm_reg[2]) begin
         filt_reg <= sync_reg[1];
         fcnt_reg <= '0;
      end else if (sync_reg[1] == filt_reg) begin
         fcnt_reg <= '0;
      end else if (fcnt_reg == FCW'(FILT_LEN - 1)) begin
         filt_reg <= sync_reg[1];
         fcnt_reg <= '0;
      end else begin
         fcnt_reg <= fcnt_reg + 1'b1;
      end
   end

   assign level = filt_reg;
`else
   assign level = sync_reg[1];
`endif

   assign rise = warm_reg[3] &  level & ~lvl_d_reg;
   assign fall = warm_reg[3] & ~level &  lvl_d_reg;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and rise-to-rise period, classifies the width,
// flags range errors and loss of signal. Define PWM_CAP_FILTER_EN for the glitch filter.
module pwm_capture
   import motor_pkg::*;
#(
   parameter int CNT_W      = 21,
   parameter int MIN_W      = 10_000,
   parameter int MAX_W      = 125_000,
   parameter int PERIOD_MIN = 500_000,
   parameter int PERIOD_MAX = 1_500_000,
   parameter int LO_THR     = 50_000,
   parameter int HI_THR     = 90_000,
   parameter int FILT_LEN   = 4
) (
   input  logic             m_clock,
   input  logic             p_reset,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] width_q,
   output logic [CNT_W-1:0] period_q,
   output logic [1:0]       cmd,
   output logic             pulse_valid,
   output logic             range_err,
   output logic             signal_lost
);

   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX_C = '1;
   localparam logic [CNT_W-1:0] MIN_W_C   = CNT_W'(MIN_W);
   localparam logic [CNT_W-1:0] MAX_W_C   = CNT_W'(MAX_W);
   localparam logic [CNT_W-1:0] PER_MIN_C = CNT_W'(PERIOD_MIN);
   localparam logic [CNT_W-1:0] PER_MAX_C = CNT_W'(PERIOD_MAX);
   localparam logic [CNT_W-1:0] LO_THR_C  = CNT_W'(LO_THR);
   localparam logic [CNT_W-1:0] HI_THR_C  = CNT_W'(HI_THR);

   logic level, rise, fall;

   cap_state_t       state_reg,  state_next;
   logic [CNT_W-1:0] hi_reg,     hi_next;
   logic [CNT_W-1:0] per_reg,    per_next;
   logic [CNT_W-1:0] width_reg,  width_next;
   logic [CNT_W-1:0] period_reg, period_next;
   cmd_t             cmd_reg,    cmd_next;
   logic             valid_reg,  valid_next;
   logic             err_reg,    err_next;
   logic             lost_reg,   lost_next;

   pwm_in_cond #(
      .FILT_LEN (FILT_LEN)
   ) u_cond (
      .m_clock (m_clock),
      .p_reset (p_reset),
      .pwm_in  (pwm_in),
      .level   (level),
      .rise    (rise),
      .fall    (fall)
   );

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX_C) ? v : v + ONE_C;
   endfunction

   function automatic cmd_t classify(input logic [CNT_W-1:0] w);
      if (w <= LO_THR_C)
         return CMD_NARROW;
      if (w >= HI_THR_C)
         return CMD_WIDE;
      return CMD_MID;
   endfunction

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         state_reg  <= IDLE;
         hi_reg     <= '0;
         per_reg    <= '0;
         width_reg  <= '0;
         period_reg <= '0;
         cmd_reg    <= CMD_MID;
         valid_reg  <= 1'b0;
         err_reg    <= 1'b0;
         lost_reg   <= 1'b1;
      end else begin
         state_reg  <= state_next;
         hi_reg     <= hi_next;
         per_reg    <= per_next;
         width_reg  <= width_next;
         period_reg <= period_next;
         cmd_reg    <= cmd_next;
         valid_reg  <= valid_next;
         err_reg    <= err_next;
         lost_reg   <= lost_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      hi_next     = hi_reg;
      per_next    = per_reg;
      width_next  = width_reg;
      period_next = period_reg;
      cmd_next    = cmd_reg;
      valid_next  = 1'b0;
      err_next    = 1'b0;
      lost_next   = lost_reg;

      case (state_reg)
         IDLE: begin
            if (rise) begin
               hi_next    = ONE_C;
               per_next   = ONE_C;
               state_next = HIGH;
            end
         end

         HIGH: begin
            if (per_reg == PER_MAX_C) begin
               state_next = IDLE;
               lost_next  = 1'b1;
            end else begin
               per_next = sat_inc(per_reg);
               if (fall)
                  state_next = LOW;
               else
                  hi_next = sat_inc(hi_reg);
            end
         end

         LOW: begin
            // The level was low on every cycle spent in LOW, so a high level here is the rise.
            if (per_reg == PER_MAX_C) begin
               state_next = IDLE;
               lost_next  = 1'b1;
            end else if (level) begin
               if ((hi_reg >= MIN_W_C) && (hi_reg <= MAX_W_C) &&
                   (per_reg >= PER_MIN_C) && (per_reg <= PER_MAX_C)) begin
                  width_next  = hi_reg;
                  period_next = per_reg;
                  cmd_next    = classify(hi_reg);
                  valid_next  = 1'b1;
                  lost_next   = 1'b0;
               end else begin
                  err_next = 1'b1;
               end
               hi_next    = ONE_C;
               per_next   = ONE_C;
               state_next = HIGH;
            end else begin
               per_next = sat_inc(per_reg);
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign width_q     = width_reg;
   assign period_q    = period_reg;
   assign cmd         = cmd_reg;
   assign pulse_valid = valid_reg;
   assign range_err   = err_reg;
   assign signal_lost = lost_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with timing parameters scaled down by 1000
// (frame = 1000 cycles) so the full sequence stays short.
module tb_pwm_capture;

   localparam int CNT_W = 21;
`ifdef PWM_CAP_FILTER_EN
   localparam int LAT = 3 + 4;
`else
   localparam int LAT = 3;
`endif

   logic             clk;
   logic             rst_n;
   logic             pwm_in;
   logic [CNT_W-1:0] width_q;
   logic [CNT_W-1:0] period_q;
   logic [1:0]       cmd;
   logic             pulse_valid;
   logic             range_err;
   logic             signal_lost;

   int tests_run    = 0;
   int tests_failed = 0;

   int cyc            = 0;
   int vc             = 0;
   int ec             = 0;
   int both_cnt       = 0;
   int last_valid_cyc = 0;
   int rise_cyc       = 0;

   int exp_vc, exp_ec, exp_w, exp_p, exp_c;
   int vc_snap, ec_snap;

   // width, period, accepted?, expected cmd for an accepted frame
   int tw[16] = '{75, 95, 17, 5, 50, 51, 89, 90, 10, 9, 125, 126, 75, 75, 75, 75};
   int tp[16] = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000,
                  1000, 1000, 1000, 1000, 500, 499, 1499, 1000};
   int ta[16] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 1};
   int tc[16] = '{0, 1, 2, 0, 2, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0};

   pwm_capture #(
      .CNT_W      (CNT_W),
      .MIN_W      (10),
      .MAX_W      (125),
      .PERIOD_MIN (500),
      .PERIOD_MAX (1500),
      .LO_THR     (50),
      .HI_THR     (90),
      .FILT_LEN   (4)
   ) dut (
      .m_clock     (clk),
      .p_reset     (rst_n),
      .pwm_in      (pwm_in),
      .width_q     (width_q),
      .period_q    (period_q),
      .cmd         (cmd),
      .pulse_valid (pulse_valid),
      .range_err   (range_err),
      .signal_lost (signal_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (pulse_valid) begin
         vc = vc + 1;
         last_valid_cyc = cyc;
      end
      if (range_err)
         ec = ec + 1;
      if (pulse_valid && range_err)
         both_cnt = both_cnt + 1;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      tests_run = tests_run + 1;
      if (obs != exp) begin
         tests_failed = tests_failed + 1;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic frame(input int w, input int p);
      @(negedge clk);
      pwm_in   = 1'b1;
      rise_cyc = cyc;
      repeat (w) @(negedge clk);
      pwm_in = 1'b0;
      repeat (p - w - 1) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_width"},  int'(width_q),     0);
      check_eq({tag, "_period"}, int'(period_q),    0);
      check_eq({tag, "_cmd"},    int'(cmd),         0);
      check_eq({tag, "_valid"},  int'(pulse_valid), 0);
      check_eq({tag, "_err"},    int'(range_err),   0);
      check_eq({tag, "_lost"},   int'(signal_lost), 1);
   endtask

   initial begin
      rst_n  = 1'b0;
      pwm_in = 1'b0;
      repeat (5) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // T1/T2/T3 and width/period boundaries: each frame's result shows during the next one
      exp_vc = 0; exp_ec = 0; exp_w = 0; exp_p = 0; exp_c = 0;
      for (int i = 0; i <= 16; i++) begin
         if (i < 16) frame(tw[i], tp[i]);
         else        frame(75, 1000);
         if (i == 0) begin
            check_eq("first_frame_no_strobe", vc, 0);
            check_eq("first_frame_lost", int'(signal_lost), 1);
         end else begin
            if (ta[i-1] != 0) begin
               exp_vc = exp_vc + 1;
               exp_w  = tw[i-1];
               exp_p  = tp[i-1];
               exp_c  = tc[i-1];
            end else begin
               exp_ec = exp_ec + 1;
            end
            check_eq("valid_count", vc, exp_vc);
            check_eq("err_count",   ec, exp_ec);
            check_eq("width_q",  int'(width_q),  exp_w);
            check_eq("period_q", int'(period_q), exp_p);
            check_eq("cmd",      int'(cmd),      exp_c);
            check_eq("signal_lost", int'(signal_lost), 0);
            if (i == 1)
               check_eq("latency", last_valid_cyc - rise_cyc, LAT);
         end
         $display("[TB] frame %0d: width_q=%0d period_q=%0d cmd=%0d valids=%0d errs=%0d",
                  i, width_q, period_q, cmd, vc, ec);
      end

      // T4: line held low until the period timeout
      vc_snap = vc;
      ec_snap = ec;
      repeat (rise_cyc + LAT + 1499 - cyc) @(negedge clk);
      check_eq("lost_before_timeout", int'(signal_lost), 0);
      @(negedge clk);
      check_eq("lost_at_timeout", int'(signal_lost), 1);
      repeat (400) @(negedge clk);
      check_eq("timeout_no_valid", vc, vc_snap);
      check_eq("timeout_no_err",   ec, ec_snap);
      frame(75, 1000);
      check_eq("restart_no_valid", vc, vc_snap);
      check_eq("restart_lost",     int'(signal_lost), 1);
      frame(75, 1000);
      check_eq("recover_valid",  vc, vc_snap + 1);
      check_eq("recover_lost",   int'(signal_lost), 0);
      check_eq("recover_width",  int'(width_q), 75);
      $display("[TB] timeout: signal_lost=%0d valids=%0d", signal_lost, vc);

      // T5: reset asserted in the middle of a high pulse and released while still high
      @(negedge clk);
      pwm_in   = 1'b1;
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("midreset");
      vc_snap = vc;
      ec_snap = ec;
      repeat (7) @(negedge clk);
      rst_n = 1'b1;
      repeat (35) @(negedge clk);
      pwm_in = 1'b0;
      repeat (1000 - 75 - 1) @(negedge clk);
      check_eq("partial_no_valid", vc, vc_snap);
      frame(75, 1000);
      check_eq("post_reset_no_valid", vc, vc_snap);
      check_eq("post_reset_no_err",   ec, ec_snap);
      check_reset_vals("post_reset");
      frame(75, 1000);
      check_eq("post_reset_valid", vc, vc_snap + 1);
      check_eq("post_reset_width", int'(width_q), 75);
      check_eq("post_reset_lost",  int'(signal_lost), 0);
      $display("[TB] reset: width_q=%0d valids=%0d", width_q, vc);

      // T6: 2-cycle low glitch inside a 75-cycle high pulse
      vc_snap = vc;
      ec_snap = ec;
      @(negedge clk);
      pwm_in   = 1'b1;
      rise_cyc = cyc;
      repeat (30) @(negedge clk);
      pwm_in = 1'b0;
      repeat (2) @(negedge clk);
      pwm_in = 1'b1;
      repeat (43) @(negedge clk);
      pwm_in = 1'b0;
      repeat (1000 - 75 - 1) @(negedge clk);
      frame(75, 1000);
      check_eq("glitch_valid_count", vc, vc_snap + 2);
`ifdef PWM_CAP_FILTER_EN
      check_eq("glitch_err_count", ec, ec_snap);
      check_eq("glitch_width",     int'(width_q),  75);
      check_eq("glitch_period",    int'(period_q), 1000);
      check_eq("glitch_cmd",       int'(cmd),      0);
`else
      check_eq("glitch_err_count", ec, ec_snap + 1);
      check_eq("glitch_width",     int'(width_q),  43);
      check_eq("glitch_period",    int'(period_q), 968);
      check_eq("glitch_cmd",       int'(cmd),      2);
`endif
      $display("[TB] glitch: width_q=%0d period_q=%0d errs=%0d", width_q, period_q, ec);

      check_eq("valid_err_overlap", both_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
